// File: rtl/e203_exu_brchslv_pipe.sv
// Commit-stage branch resolve: classifies BJP/fence.i/mret/dret, computes the redirect PC,
// optionally holds the IFU flush request until acknowledged, and counts branches/mispredicts.
module e203_exu_brchslv_pipe #(
  parameter int unsigned PC_W           = 32,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned CNT_W          = 16,
  parameter bit          REG_FLUSH      = 1'b1,
  parameter bit          CANCEL_ON_EXCP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmt_i_valid,
  output logic             cmt_i_ready,
  input  logic             cmt_i_rv32,
  input  logic             cmt_i_bjp,
  input  logic             cmt_i_bjp_prdt,
  input  logic             cmt_i_bjp_rslv,
  input  logic             cmt_i_fencei,
  input  logic             cmt_i_mret,
  input  logic             cmt_i_dret,
  input  logic [PC_W-1:0]  cmt_i_pc,
  input  logic [XLEN-1:0]  cmt_i_imm,
  input  logic [PC_W-1:0]  csr_epc_r,
  input  logic [PC_W-1:0]  csr_dpc_r,
  input  logic             nonalu_excpirq_flush_req_raw,
  output logic             brchmis_flush_req,
  input  logic             brchmis_flush_ack,
  output logic [PC_W-1:0]  brchmis_flush_pc,
  output logic             cmt_mret_ena,
  output logic             cmt_dret_ena,
  output logic             cmt_fencei_ena,
  output logic             flush_cancel,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] bjp_cnt,
  output logic [CNT_W-1:0] brchmis_cnt
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   flush_pc_q, flush_pc_d;
  logic              flush_cancel_q, flush_cancel_d;
  logic [CNT_W-1:0]  bjp_cnt_q, bjp_cnt_d;
  logic [CNT_W-1:0]  brchmis_cnt_q, brchmis_cnt_d;

  logic              mispred, need_flush, is_br, pend, nonalu, accept;
  logic [PC_W-1:0]   target;

  // Instruction classification and redirect target
  always_comb begin
    mispred    = cmt_i_bjp & (cmt_i_bjp_prdt ^ cmt_i_bjp_rslv);
    need_flush = mispred | cmt_i_fencei | cmt_i_mret | cmt_i_dret;
    is_br      = cmt_i_bjp | cmt_i_fencei | cmt_i_mret | cmt_i_dret;
    nonalu     = nonalu_excpirq_flush_req_raw;
    pend       = (state_q == PEND);
    if (cmt_i_dret)
      target = csr_dpc_r;
    else if (cmt_i_mret)
      target = csr_epc_r;
    else if (cmt_i_fencei | (cmt_i_bjp & cmt_i_bjp_prdt))
      target = cmt_i_pc + (cmt_i_rv32 ? PC_W'(4) : PC_W'(2));
    else
      target = cmt_i_pc + PC_W'(cmt_i_imm);
  end

  // Commit handshake and flush request
  always_comb begin
    if (pend)
      cmt_i_ready = 1'b0;
    else if (!is_br)
      cmt_i_ready = 1'b1;
    else if (!need_flush)
      cmt_i_ready = !nonalu;
    else
      cmt_i_ready = !nonalu & (REG_FLUSH | brchmis_flush_ack);
    accept = cmt_i_valid & cmt_i_ready;

    if (REG_FLUSH) begin
      brchmis_flush_req = pend & !nonalu;
      brchmis_flush_pc  = flush_pc_q;
    end else begin
      brchmis_flush_req = cmt_i_valid & need_flush & !nonalu & !pend;
      brchmis_flush_pc  = target;
    end
  end

  assign cmt_mret_ena   = accept & cmt_i_mret;
  assign cmt_dret_ena   = accept & cmt_i_dret;
  assign cmt_fencei_ena = accept & cmt_i_fencei;
  assign flush_cancel   = flush_cancel_q;
  assign bjp_cnt        = bjp_cnt_q;
  assign brchmis_cnt    = brchmis_cnt_q;

  // Next-state: pending flush and saturating performance counters
  always_comb begin
    state_d        = state_q;
    flush_pc_d     = flush_pc_q;
    flush_cancel_d = 1'b0;
    bjp_cnt_d      = bjp_cnt_q;
    brchmis_cnt_d  = brchmis_cnt_q;

    if (REG_FLUSH) begin
      case (state_q)
        IDLE: begin
          if (accept & need_flush) begin
            state_d    = PEND;
            flush_pc_d = target;
          end
        end
        PEND: begin
          if (nonalu & CANCEL_ON_EXCP) begin
            state_d        = IDLE;
            flush_cancel_d = 1'b1;
          end else if (brchmis_flush_req & brchmis_flush_ack) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Clear wins over a same-cycle increment
    if (cnt_clr) begin
      bjp_cnt_d     = '0;
      brchmis_cnt_d = '0;
    end else if (accept) begin
      if (cmt_i_bjp & ~&bjp_cnt_q)
        bjp_cnt_d = bjp_cnt_q + CNT_W'(1);
      if (mispred & ~&brchmis_cnt_q)
        brchmis_cnt_d = brchmis_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      flush_pc_q     <= '0;
      flush_cancel_q <= 1'b0;
      bjp_cnt_q      <= '0;
      brchmis_cnt_q  <= '0;
    end else begin
      state_q        <= state_d;
      flush_pc_q     <= flush_pc_d;
      flush_cancel_q <= flush_cancel_d;
      bjp_cnt_q      <= bjp_cnt_d;
      brchmis_cnt_q  <= brchmis_cnt_d;
    end
  end

endmodule

// File: tb/tb_e203_exu_brchslv_pipe.sv
// Bench for e203_exu_brchslv_pipe: three configurations share one stimulus stream and are
// each checked every cycle against a per-instance reference model.
module tb_e203_exu_brchslv_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid, rv32, bjp, prdt, rslv, fencei, mret, dret, nonalu, ack, clr;
  logic [31:0] pc, imm, epc, dpc;

  // u0: REG=1 CANCEL=1, u1: REG=1 CANCEL=0 CNT_W=4, u2: REG=0
  logic        rdy0, req0, mre0, dre0, fie0, cx0;
  logic        rdy1, req1, mre1, dre1, fie1, cx1;
  logic        rdy2, req2, mre2, dre2, fie2, cx2;
  logic [31:0] fpc0, fpc1, fpc2;
  logic [15:0] bc0, mc0, bc2, mc2;
  logic [3:0]  bc1, mc1;

  int errors = 0;
  int checks = 0;

  bit          m_reg  [3] = '{1'b1, 1'b1, 1'b0};
  bit          m_can  [3] = '{1'b1, 1'b0, 1'b1};
  int          m_max  [3] = '{65535, 15, 65535};
  bit          m_pend [3];
  logic [31:0] m_hold [3];
  int          m_bc   [3];
  int          m_mc   [3];
  bit          m_cx   [3];

  e203_exu_brchslv_pipe #(.PC_W(32), .XLEN(32), .CNT_W(16), .REG_FLUSH(1'b1), .CANCEL_ON_EXCP(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .cmt_i_valid(valid), .cmt_i_ready(rdy0), .cmt_i_rv32(rv32),
    .cmt_i_bjp(bjp), .cmt_i_bjp_prdt(prdt), .cmt_i_bjp_rslv(rslv), .cmt_i_fencei(fencei),
    .cmt_i_mret(mret), .cmt_i_dret(dret), .cmt_i_pc(pc), .cmt_i_imm(imm), .csr_epc_r(epc),
    .csr_dpc_r(dpc), .nonalu_excpirq_flush_req_raw(nonalu), .brchmis_flush_req(req0),
    .brchmis_flush_ack(ack), .brchmis_flush_pc(fpc0), .cmt_mret_ena(mre0), .cmt_dret_ena(dre0),
    .cmt_fencei_ena(fie0), .flush_cancel(cx0), .cnt_clr(clr), .bjp_cnt(bc0), .brchmis_cnt(mc0));

  e203_exu_brchslv_pipe #(.PC_W(32), .XLEN(32), .CNT_W(4), .REG_FLUSH(1'b1), .CANCEL_ON_EXCP(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .cmt_i_valid(valid), .cmt_i_ready(rdy1), .cmt_i_rv32(rv32),
    .cmt_i_bjp(bjp), .cmt_i_bjp_prdt(prdt), .cmt_i_bjp_rslv(rslv), .cmt_i_fencei(fencei),
    .cmt_i_mret(mret), .cmt_i_dret(dret), .cmt_i_pc(pc), .cmt_i_imm(imm), .csr_epc_r(epc),
    .csr_dpc_r(dpc), .nonalu_excpirq_flush_req_raw(nonalu), .brchmis_flush_req(req1),
    .brchmis_flush_ack(ack), .brchmis_flush_pc(fpc1), .cmt_mret_ena(mre1), .cmt_dret_ena(dre1),
    .cmt_fencei_ena(fie1), .flush_cancel(cx1), .cnt_clr(clr), .bjp_cnt(bc1), .brchmis_cnt(mc1));

  e203_exu_brchslv_pipe #(.PC_W(32), .XLEN(32), .CNT_W(16), .REG_FLUSH(1'b0), .CANCEL_ON_EXCP(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .cmt_i_valid(valid), .cmt_i_ready(rdy2), .cmt_i_rv32(rv32),
    .cmt_i_bjp(bjp), .cmt_i_bjp_prdt(prdt), .cmt_i_bjp_rslv(rslv), .cmt_i_fencei(fencei),
    .cmt_i_mret(mret), .cmt_i_dret(dret), .cmt_i_pc(pc), .cmt_i_imm(imm), .csr_epc_r(epc),
    .csr_dpc_r(dpc), .nonalu_excpirq_flush_req_raw(nonalu), .brchmis_flush_req(req2),
    .brchmis_flush_ack(ack), .brchmis_flush_pc(fpc2), .cmt_mret_ena(mre2), .cmt_dret_ena(dre2),
    .cmt_fencei_ena(fie2), .flush_cancel(cx2), .cnt_clr(clr), .bjp_cnt(bc2), .brchmis_cnt(mc2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: what the specification says each instance should show this cycle
  function automatic bit f_mis();
    return bjp & (prdt ^ rslv);
  endfunction
  function automatic bit f_need();
    return f_mis() | fencei | mret | dret;
  endfunction
  function automatic logic [31:0] f_tgt();
    if (dret) return dpc;
    if (mret) return epc;
    if (fencei || (bjp && prdt)) return pc + (rv32 ? 32'd4 : 32'd2);
    return pc + imm;
  endfunction
  function automatic bit f_ready(input int i);
    if (m_pend[i]) return 1'b0;
    if (!(bjp | fencei | mret | dret)) return 1'b1;
    if (!f_need()) return !nonalu;
    return !nonalu && (m_reg[i] || ack);
  endfunction
  function automatic bit f_req(input int i);
    if (m_reg[i]) return m_pend[i] && !nonalu;
    return valid && f_need() && !nonalu;
  endfunction

  task automatic check_inst(input int i, input logic r, input logic q, input logic [31:0] p,
                            input logic em, input logic ed, input logic ef, input logic c,
                            input logic [15:0] b, input logic [15:0] m);
    bit acc;
    acc = valid && f_ready(i);
    chk($sformatf("u%0d_ready", i), 32'(r), 32'(f_ready(i)));
    chk($sformatf("u%0d_req", i), 32'(q), 32'(f_req(i)));
    chk($sformatf("u%0d_pc", i), p, m_reg[i] ? m_hold[i] : f_tgt());
    chk($sformatf("u%0d_mret_ena", i), 32'(em), 32'(acc && mret));
    chk($sformatf("u%0d_dret_ena", i), 32'(ed), 32'(acc && dret));
    chk($sformatf("u%0d_fencei_ena", i), 32'(ef), 32'(acc && fencei));
    chk($sformatf("u%0d_cancel", i), 32'(c), 32'(m_cx[i]));
    chk($sformatf("u%0d_bjp_cnt", i), 32'(b), 32'(m_bc[i]));
    chk($sformatf("u%0d_mis_cnt", i), 32'(m), 32'(m_mc[i]));
  endtask

  task automatic model_update(input int i);
    bit acc, rq;
    acc     = valid && f_ready(i);
    rq      = f_req(i);
    m_cx[i] = 1'b0;
    if (m_reg[i]) begin
      if (m_pend[i]) begin
        if (nonalu && m_can[i]) begin
          m_pend[i] = 1'b0;
          m_cx[i]   = 1'b1;
        end else if (rq && ack) begin
          m_pend[i] = 1'b0;
        end
      end else if (acc && f_need()) begin
        m_pend[i] = 1'b1;
        m_hold[i] = f_tgt();
      end
    end
    if (clr) begin
      m_bc[i] = 0;
      m_mc[i] = 0;
    end else if (acc) begin
      if (bjp) m_bc[i] = (m_bc[i] + 1 > m_max[i]) ? m_max[i] : m_bc[i] + 1;
      if (f_mis()) m_mc[i] = (m_mc[i] + 1 > m_max[i]) ? m_max[i] : m_mc[i] + 1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 1'b0; m_hold[i] = '0; m_bc[i] = 0; m_mc[i] = 0; m_cx[i] = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    valid = 0; rv32 = 1; bjp = 0; prdt = 0; rslv = 0; fencei = 0; mret = 0; dret = 0;
    nonalu = 0; ack = 0; clr = 0; pc = '0; imm = '0; epc = '0; dpc = '0;
  endtask

  // Check at the falling edge, advance the models, leave the bench at posedge+1
  task automatic step();
    @(negedge clk);
    check_inst(0, rdy0, req0, fpc0, mre0, dre0, fie0, cx0, bc0, mc0);
    check_inst(1, rdy1, req1, fpc1, mre1, dre1, fie1, cx1, 16'(bc1), 16'(mc1));
    check_inst(2, rdy2, req2, fpc2, mre2, dre2, fie2, cx2, bc2, mc2);
    for (int i = 0; i < 3; i++) model_update(i);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle_inputs();
    ack = 1;
    repeat (3) step();
    ack = 0;
  endtask

  initial begin
    do_reset();
    step();

    // Mispredicted rv32 branch, then ack held off for 3 cycles
    valid = 1; bjp = 1; prdt = 0; rslv = 1; pc = 32'h8000_0100; imm = 32'h40;
    step();
    chk("t1_bjp_cnt", 32'(bc0), 32'd1);
    chk("t1_mis_cnt", 32'(mc0), 32'd1);
    valid = 0; bjp = 0; rslv = 0;
    #1;
    chk("t1_req", 32'(req0), 32'd1);
    chk("t1_pc", fpc0, 32'h8000_0140);
    repeat (3) step();
    ack = 1;
    step();
    ack = 0;
    #1;
    chk("t2_ready_after_ack", 32'(rdy0), 32'd1);
    chk("t2_req_after_ack", 32'(req0), 32'd0);
    drain();

    // mret with a non-ALU flush in the second pending cycle
    valid = 1; mret = 1; epc = 32'h8000_2000; ack = 0;
    step();
    valid = 0; mret = 0;
    step();
    nonalu = 1;
    step();
    nonalu = 0;
    #1;
    chk("t3_cancel_pulse", 32'(cx0), 32'd1);
    chk("t3_cancel_idle", 32'(rdy0), 32'd1);
    chk("t3_nocancel_req", 32'(req1), 32'd1);
    chk("t3_nocancel_pc", fpc1, 32'h8000_2000);
    drain();

    // Combinational flush of a predicted-taken rv16 branch
    valid = 1; rv32 = 0; bjp = 1; prdt = 1; rslv = 0; pc = 32'h0000_01FE; ack = 1;
    #1;
    chk("t4_req", 32'(req2), 32'd1);
    chk("t4_pc", fpc2, 32'h0000_0200);
    chk("t4_ready", 32'(rdy2), 32'd1);
    step();
    drain();

    // fence.i at the top of the address space wraps
    valid = 1; rv32 = 1; fencei = 1; pc = 32'hFFFF_FFFE; ack = 1;
    #1;
    chk("t5_pc_comb", fpc2, 32'h0000_0002);
    chk("t5_fencei_ena", 32'(fie2), 32'd1);
    step();
    valid = 0; fencei = 0;
    #1;
    chk("t5_pc_reg", fpc0, 32'h0000_0002);
    drain();

    // Saturate the 4-bit mispredict counter, then clear against an increment
    valid = 1; bjp = 1; prdt = 0; rslv = 1; pc = 32'h100; imm = 32'h20; ack = 1;
    repeat (40) step();
    chk("t6_sat", 32'(mc1), 32'hF);
    clr = 1;
    repeat (2) step();
    clr = 0; valid = 0;
    #1;
    chk("t6_clr", 32'(mc1), 32'h0);
    drain();

    // Reset while a flush is pending
    valid = 1; dret = 1; dpc = 32'h0000_4000; ack = 0;
    step();
    valid = 0; dret = 0;
    #1;
    chk("t6_pend_req", 32'(req0), 32'd1);
    rst_n = 0;
    #1;
    chk("t6_rst_req0", 32'(req0), 32'd0);
    chk("t6_rst_req1", 32'(req1), 32'd0);
    do_reset();
    step();

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      valid  = ($urandom_range(0, 9) < 7);
      rv32   = 1'($urandom);
      bjp    = ($urandom_range(0, 9) < 5);
      prdt   = 1'($urandom);
      rslv   = 1'($urandom);
      fencei = ($urandom_range(0, 19) == 0);
      mret   = ($urandom_range(0, 19) == 0);
      dret   = ($urandom_range(0, 29) == 0);
      nonalu = ($urandom_range(0, 9) < 2);
      ack    = 1'($urandom);
      clr    = ($urandom_range(0, 49) == 0);
      pc     = $urandom & 32'hFFFF_FFFE;
      imm    = $urandom;
      epc    = $urandom;
      dpc    = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
